// File: rtl/regfile_writeback.sv
// Writeback arbiter: two producers into an in-order FIFO, drained onto
// register-file write ports c and d, with a pending-write busy scoreboard.
module regfile_writeback #(
  parameter  int LOG_REG_CNT       = 2,
  parameter  int SUPERSCALAR_WIDTH = 4,
  parameter  int REG_WIDTH         = 288,
  parameter  int DEPTH             = 4,
  localparam int AW   = LOG_REG_CNT * SUPERSCALAR_WIDTH,
  localparam int NREG = (1 << LOG_REG_CNT) * SUPERSCALAR_WIDTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 freeze,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [AW-1:0]        in0_addr,
  input  logic [REG_WIDTH-1:0] in0_data,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [AW-1:0]        in1_addr,
  input  logic [REG_WIDTH-1:0] in1_data,
  output logic                 port_c_we,
  output logic                 port_d_we,
  output logic [AW-1:0]        port_c_write_addr,
  output logic [AW-1:0]        port_d_write_addr,
  output logic [REG_WIDTH-1:0] port_c_in,
  output logic [REG_WIDTH-1:0] port_d_in,
  output logic [NREG-1:0]      busy,
  output logic [CW-1:0]        count
);

  logic [AW-1:0]        addr_q [DEPTH];
  logic [REG_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d, head1, slot1;
  logic [CW-1:0]        count_q, count_d;
  logic                 c_we_q, c_we_d, d_we_q, d_we_d;
  logic [AW-1:0]        c_addr_q, d_addr_q;
  logic [REG_WIDTH-1:0] c_data_q, d_data_q;
  logic                 fire0, fire1, pop1, pop2;

  assign in0_ready = !freeze && (count_q < CW'(DEPTH));
  assign in1_ready = !freeze && (count_q <= CW'(DEPTH - 2));

  always_comb begin
    fire0   = in0_valid && in0_ready;
    fire1   = in1_valid && in1_ready;
    head1   = head_q + PW'(1);
    slot1   = tail_q + PW'(fire0);
    pop1    = !freeze && (count_q != '0);
    // Same-register pairs go out one per cycle to keep last-writer order.
    pop2    = !freeze && (count_q >= CW'(2))
              && (addr_q[head1] != addr_q[head_q]);
    tail_d  = tail_q + PW'(fire0) + PW'(fire1);
    head_d  = head_q + PW'(pop1) + PW'(pop2);
    count_d = count_q + CW'(fire0) + CW'(fire1)
              - CW'(pop1) - CW'(pop2);
    c_we_d  = freeze ? c_we_q : pop1;
    d_we_d  = freeze ? d_we_q : pop2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      c_we_q   <= 1'b0;
      d_we_q   <= 1'b0;
      c_addr_q <= '0;
      d_addr_q <= '0;
      c_data_q <= '0;
      d_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      c_we_q  <= c_we_d;
      d_we_q  <= d_we_d;
      if (fire0) begin
        addr_q[tail_q] <= in0_addr;
        data_q[tail_q] <= in0_data;
      end
      if (fire1) begin
        addr_q[slot1] <= in1_addr;
        data_q[slot1] <= in1_data;
      end
      if (pop1) begin
        c_addr_q <= addr_q[head_q];
        c_data_q <= data_q[head_q];
      end
      if (pop2) begin
        d_addr_q <= addr_q[head1];
        d_data_q <= data_q[head1];
      end
    end
  end

  // Out-of-range addresses match no r, so they never mark a register busy.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        for (int r = 0; r < NREG; r++) begin
          if (addr_q[head_q + PW'(i)] == AW'(r)) busy[r] = 1'b1;
        end
      end
    end
    for (int r = 0; r < NREG; r++) begin
      if (c_we_q && c_addr_q == AW'(r)) busy[r] = 1'b1;
      if (d_we_q && d_addr_q == AW'(r)) busy[r] = 1'b1;
    end
  end

  assign port_c_we         = c_we_q;
  assign port_d_we         = d_we_q;
  assign port_c_write_addr = c_addr_q;
  assign port_d_write_addr = d_addr_q;
  assign port_c_in         = c_data_q;
  assign port_d_in         = d_data_q;
  assign count             = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vectors, expected writes queued
// at issue and popped by a monitor at each committing write.
module tb_regfile_writeback;

  localparam int AW = 8;
  localparam int RW = 288;
  localparam int NR = 16;

  typedef struct packed {
    logic          p;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
  } exp_t;

  logic          clk, reset, freeze;
  logic          in0_valid, in0_ready, in1_valid, in1_ready;
  logic [AW-1:0] in0_addr, in1_addr;
  logic [RW-1:0] in0_data, in1_data;
  logic          port_c_we, port_d_we;
  logic [AW-1:0] port_c_write_addr, port_d_write_addr;
  logic [RW-1:0] port_c_in, port_d_in;
  logic [NR-1:0] busy;
  logic [2:0]    count;

  exp_t          q[$];
  logic [RW-1:0] regs [NR];
  int            checks = 0;
  int            errors = 0;

  regfile_writeback dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in1_addr(in1_addr), .in1_data(in1_data),
    .port_c_we(port_c_we), .port_d_we(port_d_we),
    .port_c_write_addr(port_c_write_addr),
    .port_d_write_addr(port_d_write_addr),
    .port_c_in(port_c_in), .port_d_in(port_d_in),
    .busy(busy), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] mk(input logic [31:0] s);
    return {9{s}};
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic v0, input logic [AW-1:0] a0,
                      input logic [RW-1:0] d0, input logic v1,
                      input logic [AW-1:0] a1, input logic [RW-1:0] d1);
    in0_valid = v0; in0_addr = a0; in0_data = d0;
    in1_valid = v1; in1_addr = a1; in1_data = d1;
    step(1);
    in0_valid = 0;
    in1_valid = 0;
  endtask

  task automatic expw(input logic p, input logic [AW-1:0] a,
                      input logic [RW-1:0] d);
    q.push_back('{p: p, a: a, d: d});
  endtask

  task automatic pop_chk(input logic p, input logic [AW-1:0] a,
                         input logic [RW-1:0] d);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: port %0d addr %0d", p, a);
    end else begin
      e = q.pop_front();
      chk(p ? "d_port" : "c_port", RW'(p), RW'(e.p));
      chk(p ? "d_addr" : "c_addr", RW'(a), RW'(e.a));
      chk(p ? "d_data" : "c_data", d, e.d);
    end
    if (a < NR) regs[a[3:0]] = d;
  endtask

  // Inputs change #1 after posedge, so freeze here is what the next edge sees.
  always @(negedge clk) begin
    if (reset && !freeze) begin
      if (port_c_we) pop_chk(1'b0, port_c_write_addr, port_c_in);
      if (port_d_we) pop_chk(1'b1, port_d_write_addr, port_d_in);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = '0;
    reset = 0; freeze = 0;
    in0_valid = 1; in0_addr = 8'd5; in0_data = mk(32'hdead0000);
    in1_valid = 0; in1_addr = '0; in1_data = '0;
    step(3);
    chk("rst_c_we", RW'(port_c_we), '0);
    chk("rst_d_we", RW'(port_d_we), '0);
    chk("rst_busy", RW'(busy), '0);
    chk("rst_count", RW'(count), '0);
    reset = 1;
    in0_valid = 0;
    #1;
    chk("rst_in0_ready", RW'(in0_ready), RW'(1));
    step(1);

    // single write
    expw(0, 8'd5, mk(32'haaaa0005));
    push(1, 8'd5, mk(32'haaaa0005), 0, '0, '0);
    chk("single_busy5", RW'(busy), RW'(16'h0020));
    chk("single_count", RW'(count), RW'(1));
    step(1);
    chk("single_c_we", RW'(port_c_we), RW'(1));
    chk("single_c_addr", RW'(port_c_write_addr), RW'(5));
    step(1);
    chk("single_busy_clr", RW'(busy), '0);
    chk("single_reg5", regs[5], mk(32'haaaa0005));

    // dual issue, distinct registers
    expw(0, 8'd1, mk(32'h11110001));
    expw(1, 8'd2, mk(32'h22220002));
    push(1, 8'd1, mk(32'h11110001), 1, 8'd2, mk(32'h22220002));
    chk("dual_busy", RW'(busy), RW'(16'h0006));
    step(1);
    chk("dual_c_we", RW'(port_c_we), RW'(1));
    chk("dual_d_we", RW'(port_d_we), RW'(1));
    step(2);

    // same-address hazard
    expw(0, 8'd3, mk(32'h33330050));
    expw(0, 8'd3, mk(32'h33330051));
    push(1, 8'd3, mk(32'h33330050), 1, 8'd3, mk(32'h33330051));
    step(1);
    chk("haz_d_we", RW'(port_d_we), '0);
    chk("haz_count", RW'(count), RW'(1));
    step(1);
    chk("haz_c_data2", port_c_in, mk(32'h33330051));
    step(2);
    chk("haz_reg3", regs[3], mk(32'h33330051));

    // backpressure and freeze, all targeting r7 so drain is 1/cycle
    expw(0, 8'd7, mk(32'h77770000));
    expw(0, 8'd7, mk(32'h77770001));
    expw(0, 8'd7, mk(32'h77770002));
    expw(0, 8'd7, mk(32'h77770003));
    push(1, 8'd7, mk(32'h77770000), 1, 8'd7, mk(32'h77770001));
    chk("bp_count2", RW'(count), RW'(2));
    chk("bp_in0_rdy2", RW'(in0_ready), RW'(1));
    chk("bp_in1_rdy2", RW'(in1_ready), RW'(1));
    push(1, 8'd7, mk(32'h77770002), 1, 8'd7, mk(32'h77770003));
    chk("bp_count3", RW'(count), RW'(3));
    chk("bp_in0_rdy3", RW'(in0_ready), RW'(1));
    chk("bp_in1_rdy3", RW'(in1_ready), '0);
    freeze = 1;
    #1;
    chk("frz_in0_rdy", RW'(in0_ready), '0);
    chk("frz_in1_rdy", RW'(in1_ready), '0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("frz_count", RW'(count), RW'(3));
      chk("frz_c_we", RW'(port_c_we), RW'(1));
      chk("frz_c_data", port_c_in, mk(32'h77770000));
      chk("frz_d_we", RW'(port_d_we), '0);
      chk("frz_busy", RW'(busy), RW'(16'h0080));
    end
    freeze = 0;
    step(6);
    chk("bp_reg7", regs[7], mk(32'h77770003));
    chk("bp_count0", RW'(count), '0);

    // address beyond NREG passes through without busy
    expw(0, 8'd20, mk(32'h20200020));
    expw(1, 8'd4, mk(32'h44440004));
    push(1, 8'd20, mk(32'h20200020), 1, 8'd4, mk(32'h44440004));
    chk("oor_busy_q", RW'(busy), RW'(16'h0010));
    step(1);
    chk("oor_busy_p", RW'(busy), RW'(16'h0010));
    chk("oor_c_addr", RW'(port_c_write_addr), RW'(20));
    step(2);
    chk("oor_reg4", regs[4], mk(32'h44440004));

    // reset mid-stream discards everything at once
    push(1, 8'd10, mk(32'haa), 1, 8'd11, mk(32'hbb));
    push(1, 8'd12, mk(32'hcc), 1, 8'd13, mk(32'hdd));
    reset = 0;
    #1;
    chk("mid_rst_c_we", RW'(port_c_we), '0);
    chk("mid_rst_d_we", RW'(port_d_we), '0);
    chk("mid_rst_count", RW'(count), '0);
    chk("mid_rst_busy", RW'(busy), '0);
    step(1);
    reset = 1;
    step(3);
    chk("queue_empty", RW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
